// File: rtl/gate_check_sequencer.sv
// Self-test harness for the MUX2X1 gate-equivalence block: sweeps {a,b} through 00..11 for
// N_PASSES sweeps, samples fail_i after SETTLE_CYCLES, and keeps a saturating error count.
module gate_check_sequencer #(
  parameter int N_PASSES      = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             fail_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_vec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam logic [CNT_W-1:0] ERR_MAX    = {CNT_W{1'b1}};
  localparam logic [SW-1:0]    SETTLE_END = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    SWEEP_END  = PW'(N_PASSES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state_q;
  logic [1:0]      vec_q;
  logic [PW-1:0]   sweep_q;
  logic [SW-1:0]   settle_q;
  logic [CNT_W-1:0] err_d;
  logic [1:0]      vec_d;
  logic            last_vec;

  always_comb begin
    err_d = err_cnt;
    if (fail_i && (err_cnt != ERR_MAX)) begin
      err_d = err_cnt + 1'b1;
    end
    vec_d    = vec_q + 2'd1;
    last_vec = (vec_q == 2'b11) && (sweep_q == SWEEP_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      vec_q          <= 2'b00;
      sweep_q        <= '0;
      settle_q       <= '0;
      a_o            <= 1'b0;
      b_o            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= 2'b00;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q        <= SETTLE;
            vec_q          <= 2'b00;
            sweep_q        <= '0;
            settle_q       <= '0;
            a_o            <= 1'b0;
            b_o            <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= 2'b00;
          end
        end
        SETTLE: begin
          if (settle_q == SETTLE_END) begin
            settle_q <= '0;
            state_q  <= SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SAMPLE: begin
          if (fail_i) begin
            err_cnt <= err_d;
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_vec <= vec_q;
            end
          end
          if (last_vec) begin
            state_q <= DONE;
            vec_q   <= 2'b00;
            sweep_q <= '0;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            // err_d only moves when fail_i is high, so this is the post-update count.
            pass    <= (err_d == '0);
          end else begin
            state_q <= SETTLE;
            vec_q   <= vec_d;
            a_o     <= vec_d[1];
            b_o     <= vec_d[0];
            if (vec_q == 2'b11) begin
              sweep_q <= sweep_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
